// File: rtl/kernel_run_ctrl_pkg.sv
// Shared definitions for the kernel run controller and the kernel RAM banks:
// FSM state encoding and a width helper.
package kernel_run_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StStart    = 2'd1,
      StWaitDone = 2'd2,
      StSwap     = 2'd3
   } run_state_e;

   // Ceiling log2, never below 1 so single-entry selectors still get a bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/kernel_run_ctrl_sync_3ff.sv
// Three-flop level synchronizer with asynchronous active-high reset.
module sync_3ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [2:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], d};
      end
   end

   assign q = sync_q[2];

endmodule

// File: rtl/kernel_run_ctrl.sv
// Drives an HLS ap_ctrl_hs kernel from a VIO trigger level, measures run latency
// and rotates the preloaded dataset every DATASET_UPDATE_INV completed runs.
module kernel_run_ctrl
   import kernel_run_ctrl_pkg::*;
#(
   parameter int unsigned DATASET_NUM        = 8,
   parameter int unsigned DATASET_UPDATE_INV = 1,
   parameter int unsigned RUN_CNT_W          = 16,
   parameter int unsigned LAT_CNT_W          = 32
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic                          trigger_in,
   output logic                          ap_start,
   input  logic                          ap_ready,
   input  logic                          ap_done,
   output logic [clog2(DATASET_NUM)-1:0] ds_sel,
   output logic                          ds_swap_req,
   input  logic                          ds_swap_ack,
   output logic                          busy,
   output logic [RUN_CNT_W-1:0]          run_cnt,
   output logic [LAT_CNT_W-1:0]          lat_value,
   output logic                          lat_valid
);

   localparam int unsigned DsW  = clog2(DATASET_NUM);
   localparam int unsigned IntW = clog2(DATASET_UPDATE_INV + 1);
   localparam logic [DsW-1:0]       DsLast  = DsW'(DATASET_NUM - 1);
   localparam logic [IntW-1:0]      IntLast = IntW'(DATASET_UPDATE_INV);
   localparam logic [LAT_CNT_W-1:0] LatOne  = LAT_CNT_W'(1);

   run_state_e      state;
   run_state_e      state_next;
   logic            trig_sync;
   logic            run_done;
   logic            swap_due;
   logic [IntW-1:0] int_cnt;
   logic [IntW-1:0] int_inc;
   logic [LAT_CNT_W-1:0] lat_cnt;

   sync_3ff u_trig_sync (
      .clk (ap_clk),
      .rst (ap_rst),
      .d   (trigger_in),
      .q   (trig_sync)
   );

   assign int_inc  = int_cnt + 1'b1;
   assign swap_due = (int_inc == IntLast);

   always_comb begin
      state_next = state;
      run_done   = 1'b0;
      unique case (state)
         StIdle: if (trig_sync) state_next = StStart;
         StStart: begin
            if (ap_ready) begin
               if (ap_done) run_done = 1'b1;
               else         state_next = StWaitDone;
            end
         end
         StWaitDone: run_done = ap_done;
         StSwap: if (ds_swap_ack) state_next = trig_sync ? StStart : StIdle;
         default: state_next = StIdle;
      endcase
      if (run_done) begin
         state_next = swap_due ? StSwap : (trig_sync ? StStart : StIdle);
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state       <= StIdle;
         ap_start    <= 1'b0;
         ds_swap_req <= 1'b0;
         busy        <= 1'b0;
         lat_valid   <= 1'b0;
         ds_sel      <= '0;
         run_cnt     <= '0;
         lat_value   <= '0;
         int_cnt     <= '0;
         lat_cnt     <= '0;
      end else begin
         state       <= state_next;
         ap_start    <= (state_next == StStart);
         ds_swap_req <= (state_next == StSwap);
         busy        <= (state_next != StIdle);
         lat_valid   <= run_done;
         if (run_done) begin
            run_cnt   <= run_cnt + 1'b1;
            lat_value <= lat_cnt;
            int_cnt   <= swap_due ? '0 : int_inc;
         end
         if (state == StSwap && ds_swap_ack) begin
            ds_sel <= (ds_sel == DsLast) ? '0 : ds_sel + 1'b1;
         end
         // A fresh start (including back-to-back runs) counts its first cycle as 1.
         if (state_next == StStart && (state != StStart || run_done)) begin
            lat_cnt <= LatOne;
         end else if ((state == StStart || state == StWaitDone) && lat_cnt != '1) begin
            lat_cnt <= lat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Scoreboard bench for kernel_run_ctrl: one instance swapping every run, one every third run.
module tb_kernel_run_ctrl;

   localparam int DS_NUM  = 8;
   localparam int ACK_DLY = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1, trig_a = 1'b0, rdy_a = 1'b0, done_a = 1'b0;
   logic        ack_auto_a = 1'b0, ack_man_a = 1'b0;
   logic        start_a, req_a, busy_a, latv_a;
   logic [2:0]  sel_a;
   logic [15:0] runs_a;
   logic [31:0] lat_a;

   logic        rst_b = 1'b1, trig_b = 1'b0, rdy_b = 1'b0, done_b = 1'b0, ack_b = 1'b0;
   logic        start_b, req_b, busy_b, latv_b;
   logic [2:0]  sel_b;
   logic [15:0] runs_b;
   logic [31:0] lat_b;

   int errors = 0;
   int checks = 0;

   logic [47:0] lat_q_a[$];
   logic [47:0] lat_q_b[$];
   logic [2:0]  sel_q_a[$];
   logic [15:0] swap_runs_b[$];
   logic [47:0] e_a, e_b;
   logic [2:0]  prev_sel_a = 3'd0;
   int          model_sel_a = 0, swaps_a = 0, req_run_a = 0;
   bit          ack_en_a = 1'b1;
   int          req_run_b = 0, kcnt_b = 0, starts_b = 0, runs_model_b = 0;

   kernel_run_ctrl #(
      .DATASET_NUM(DS_NUM), .DATASET_UPDATE_INV(1), .RUN_CNT_W(16), .LAT_CNT_W(32)
   ) dut_a (
      .ap_clk(clk), .ap_rst(rst_a), .trigger_in(trig_a), .ap_start(start_a),
      .ap_ready(rdy_a), .ap_done(done_a), .ds_sel(sel_a), .ds_swap_req(req_a),
      .ds_swap_ack(ack_auto_a | ack_man_a), .busy(busy_a), .run_cnt(runs_a),
      .lat_value(lat_a), .lat_valid(latv_a)
   );

   kernel_run_ctrl #(
      .DATASET_NUM(DS_NUM), .DATASET_UPDATE_INV(3), .RUN_CNT_W(16), .LAT_CNT_W(32)
   ) dut_b (
      .ap_clk(clk), .ap_rst(rst_b), .trigger_in(trig_b), .ap_start(start_b),
      .ap_ready(rdy_b), .ap_done(done_b), .ds_sel(sel_b), .ds_swap_req(req_b),
      .ds_swap_ack(ack_b), .busy(busy_b), .run_cnt(runs_b),
      .lat_value(lat_b), .lat_valid(latv_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for ap_start, then drives ready at offset rd and done at offset dd.
   task automatic run_a(input int rd, input int dd, input int run_no, input bit last,
                        output int waited);
      int drop_at;
      waited  = 0;
      drop_at = (rd + 1 > dd) ? dd : rd + 1;
      while (!start_a && waited < 60) begin
         tick();
         waited++;
      end
      check_eq("start_seen", start_a, 1);
      for (int k = 0; k <= dd; k++) begin
         if (k <= rd) check_eq("ap_start_hold", start_a, 1);
         if (k == rd + 1) check_eq("ap_start_drop", start_a, 0);
         check_eq("busy_in_run", busy_a, 1);
         rdy_a  = (k == rd);
         done_a = (k == dd);
         if (k == dd) lat_q_a.push_back({16'(run_no), 32'(dd + 1)});
         if (last && k == drop_at) trig_a = 1'b0;
         tick();
      end
      rdy_a  = 1'b0;
      done_a = 1'b0;
   endtask

   task automatic wait_idle_a();
      int n = 0;
      while (busy_a && n < 200) begin
         tick();
         n++;
      end
      check_eq("idle_reached", busy_a, 0);
   endtask

   task automatic quiet_window_a(input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (start_a || req_a) seen++;
         tick();
      end
      check_eq("no_restart", seen, 0);
   endtask

   task automatic reset_a();
      rst_a    = 1'b1;
      trig_a   = 1'b0;
      ack_en_a = 1'b1;
      tick();
      tick();
      lat_q_a.delete();
      sel_q_a.delete();
      model_sel_a = 0;
      swaps_a     = 0;
      rst_a       = 1'b0;
      tick();
   endtask

   // Swap-bank responders: acknowledge after ACK_DLY cycles of ds_swap_req.
   initial begin
      forever begin
         tick();
         ack_auto_a = 1'b0;
         if (req_a && ack_en_a && !rst_a) begin
            req_run_a++;
            if (req_run_a == ACK_DLY) begin
               ack_auto_a  = 1'b1;
               req_run_a   = 0;
               swaps_a++;
               model_sel_a = (model_sel_a + 1) % DS_NUM;
               sel_q_a.push_back(3'(model_sel_a));
            end
         end else begin
            req_run_a = 0;
         end
      end
   end

   initial begin
      forever begin
         tick();
         ack_b  = 1'b0;
         rdy_b  = 1'b0;
         done_b = 1'b0;
         if (req_b && !rst_b) begin
            req_run_b++;
            if (req_run_b == ACK_DLY) begin
               ack_b     = 1'b1;
               req_run_b = 0;
               swap_runs_b.push_back(runs_b);
            end
         end else begin
            req_run_b = 0;
         end
         // Kernel model for instance B: ready at once, done 3 cycles later.
         if (kcnt_b > 0) begin
            kcnt_b--;
            if (kcnt_b == 0) begin
               done_b = 1'b1;
               runs_model_b++;
               lat_q_b.push_back({16'(runs_model_b), 32'd4});
            end
         end else if (start_b) begin
            rdy_b  = 1'b1;
            kcnt_b = 3;
            starts_b++;
         end
      end
   end

   always @(negedge clk) begin
      if (latv_a) begin
         if (lat_q_a.size() == 0) begin
            check_eq("lat_valid_a_unexpected", latv_a, 0);
         end else begin
            e_a = lat_q_a.pop_front();
            check_eq("lat_value_a", lat_a, e_a[31:0]);
            check_eq("run_cnt_a", runs_a, e_a[47:32]);
         end
      end
      if (rst_a) begin
         prev_sel_a = sel_a;
      end else if (sel_a != prev_sel_a) begin
         if (sel_q_a.size() == 0) check_eq("ds_sel_a_unexpected", sel_a, prev_sel_a);
         else check_eq("ds_sel_a_seq", sel_a, sel_q_a.pop_front());
         prev_sel_a = sel_a;
      end
      if (latv_b) begin
         if (lat_q_b.size() == 0) begin
            check_eq("lat_valid_b_unexpected", latv_b, 0);
         end else begin
            e_b = lat_q_b.pop_front();
            check_eq("lat_value_b", lat_b, e_b[31:0]);
            check_eq("run_cnt_b", runs_b, e_b[47:32]);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) tick();
      check_eq("rst_ap_start", start_a, 0);
      check_eq("rst_swap_req", req_a, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_lat_valid", latv_a, 0);
      check_eq("rst_ds_sel", sel_a, 0);
      check_eq("rst_run_cnt", runs_a, 0);
      check_eq("rst_lat_value", lat_a, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();
      tick();
      check_eq("idle_busy", busy_a, 0);

      // Single run: trigger at cycle 0, ready at 5, done at 20, trigger dropped in WAIT_DONE.
      trig_a = 1'b1;
      run_a(1, 16, 1, 1'b1, n);
      check_eq("start_rise_cycle", n, 4);
      check_eq("swap_req_after_run", req_a, 1);
      wait_idle_a();
      quiet_window_a(12);
      check_eq("single_run_cnt", runs_a, 1);
      check_eq("single_ds_sel", sel_a, 1);
      check_eq("single_lat_drained", lat_q_a.size(), 0);

      // Eight back-to-back runs with a swap after each.
      reset_a();
      trig_a = 1'b1;
      for (int i = 1; i <= 8; i++) run_a(1, 3 + i, i, i == 8, n);
      wait_idle_a();
      quiet_window_a(12);
      check_eq("eight_run_cnt", runs_a, 8);
      check_eq("eight_swaps", swaps_a, 8);
      check_eq("eight_ds_sel", sel_a, 0);
      check_eq("eight_sel_drained", sel_q_a.size(), 0);
      check_eq("eight_lat_drained", lat_q_a.size(), 0);

      // ap_ready and ap_done together in the first START cycle.
      reset_a();
      trig_a = 1'b1;
      run_a(0, 0, 1, 1'b1, n);
      check_eq("coincide_start_low", start_a, 0);
      check_eq("coincide_run_cnt", runs_a, 1);
      wait_idle_a();
      check_eq("coincide_run_cnt_final", runs_a, 1);
      check_eq("coincide_lat_drained", lat_q_a.size(), 0);

      // Reset while holding a swap request.
      reset_a();
      trig_a = 1'b1;
      run_a(0, 2, 1, 1'b0, n);
      run_a(0, 2, 2, 1'b1, n);
      ack_en_a = 1'b0;
      n = 0;
      while (!req_a && n < 20) begin
         tick();
         n++;
      end
      tick();
      tick();
      check_eq("swap_req_held", req_a, 1);
      check_eq("sel_before_rst", sel_a, 1);
      #2;
      rst_a = 1'b1;
      #1;
      check_eq("async_rst_swap_req", req_a, 0);
      check_eq("async_rst_ap_start", start_a, 0);
      check_eq("async_rst_ds_sel", sel_a, 0);
      check_eq("async_rst_busy", busy_a, 0);
      tick();
      tick();
      lat_q_a.delete();
      sel_q_a.delete();
      model_sel_a = 0;
      rst_a       = 1'b0;
      tick();
      ack_man_a = 1'b1;
      tick();
      ack_man_a = 1'b0;
      tick();
      tick();
      check_eq("late_ack_sel", sel_a, 0);
      check_eq("late_ack_busy", busy_a, 0);
      check_eq("late_ack_req", req_a, 0);

      // Instance B: swap every third run, six runs.
      trig_b = 1'b1;
      n = 0;
      while (starts_b < 6 && n < 400) begin
         tick();
         n++;
      end
      trig_b = 1'b0;
      n = 0;
      tick();
      while (busy_b && n < 400) begin
         tick();
         n++;
      end
      check_eq("b_idle_reached", busy_b, 0);
      check_eq("b_run_cnt", runs_b, 6);
      check_eq("b_swap_count", swap_runs_b.size(), 2);
      if (swap_runs_b.size() == 2) begin
         check_eq("b_first_swap_after", swap_runs_b[0], 3);
         check_eq("b_second_swap_after", swap_runs_b[1], 6);
      end
      check_eq("b_ds_sel", sel_b, 2);
      check_eq("b_lat_drained", lat_q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
